// File: rtl/prco_mem_wb.sv
// PRCO memory/writeback stage: completes LW/SW over a req/ack RAM port, writes
// the register file, loads the PC on taken branches and re-enables fetch.
`ifndef PRCO_OP_NOP
`define PRCO_OP_NOP   5'd0
`define PRCO_OP_MOV   5'd1
`define PRCO_OP_MOVI  5'd2
`define PRCO_OP_ADD   5'd3
`define PRCO_OP_ADDI  5'd4
`define PRCO_OP_SUBI  5'd5
`define PRCO_OP_CMP   5'd6
`define PRCO_OP_JMP   5'd7
`define PRCO_OP_LW    5'd8
`define PRCO_OP_SW    5'd9
`define PRCO_OP_READ  5'd10
`define PRCO_OP_WRITE 5'd11
`endif

module prco_mem_wb #(
    parameter int RAM_TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_ce_ram,
    input  logic        i_ce_reg,
    input  logic        i_should_branch,
    input  logic [4:0]  i_op,
    input  logic [15:0] i_result,
    input  logic [15:0] i_store_data,
    input  logic [2:0]  i_rd_sel,
    input  logic [15:0] i_branch_target,
    output logic        q_ram_req,
    output logic        q_ram_we,
    output logic [15:0] q_ram_addr,
    output logic [15:0] q_ram_wdata,
    input  logic        i_ram_ack,
    input  logic [15:0] i_ram_rdata,
    output logic        q_reg_we,
    output logic [2:0]  q_reg_sel,
    output logic [15:0] q_reg_wdata,
    output logic        q_pc_load,
    output logic [15:0] q_pc_target,
    output logic        q_ce_fetch,
    output logic        q_bus_err,
    output logic        q_overrun
);

    localparam int CW = (RAM_TIMEOUT < 1) ? 1 : $clog2(RAM_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = (RAM_TIMEOUT == 0) ? '0 : CW'(RAM_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {S_IDLE, S_RAM_WAIT, S_WB} state_t;

    state_t        state_q, state_d;
    logic [4:0]    op_q, op_d;
    logic [2:0]    rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ram_req_q, ram_req_d, ram_we_q, ram_we_d;
    logic [15:0]   ram_addr_q, ram_addr_d, ram_wdata_q, ram_wdata_d;
    logic          reg_we_q, reg_we_d;
    logic [2:0]    reg_sel_q, reg_sel_d;
    logic [15:0]   reg_wdata_q, reg_wdata_d;
    logic          pc_load_q, pc_load_d;
    logic [15:0]   pc_target_q, pc_target_d;
    logic          ce_fetch_q, ce_fetch_d, bus_err_q, bus_err_d, overrun_q, overrun_d;

    function automatic logic op_writes_reg(input logic [4:0] op);
        case (op)
            `PRCO_OP_MOV, `PRCO_OP_MOVI, `PRCO_OP_ADD,
            `PRCO_OP_ADDI, `PRCO_OP_SUBI, `PRCO_OP_READ: op_writes_reg = 1'b1;
            default:                                     op_writes_reg = 1'b0;
        endcase
    endfunction

    // Next-state and output computation; pulse outputs default to zero each cycle.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rd_d        = rd_q;
        cnt_d       = cnt_q;
        ram_req_d   = ram_req_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        reg_we_d    = 1'b0;
        reg_sel_d   = 3'd0;
        reg_wdata_d = 16'h0000;
        pc_load_d   = 1'b0;
        pc_target_d = 16'h0000;
        ce_fetch_d  = 1'b0;
        bus_err_d   = 1'b0;
        overrun_d   = overrun_q;
        case (state_q)
            S_IDLE: begin
                if (i_ce_ram) begin
                    op_d        = i_op;
                    rd_d        = i_rd_sel;
                    cnt_d       = '0;
                    ram_req_d   = 1'b1;
                    ram_we_d    = (i_op == `PRCO_OP_SW);
                    ram_addr_d  = i_result;
                    ram_wdata_d = i_store_data;
                    state_d     = S_RAM_WAIT;
                end else if (i_ce_reg) begin
                    op_d       = i_op;
                    rd_d       = i_rd_sel;
                    ce_fetch_d = 1'b1;
                    state_d    = S_WB;
                    if (i_should_branch) begin
                        pc_load_d   = 1'b1;
                        pc_target_d = i_branch_target;
                    end else if (op_writes_reg(i_op)) begin
                        reg_we_d    = 1'b1;
                        reg_sel_d   = i_rd_sel;
                        reg_wdata_d = i_result;
                    end else begin
                        reg_we_d = 1'b0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RAM_WAIT: begin
                if (i_ce_ram || i_ce_reg) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
                // An ack on the expiry cycle is checked first and so wins.
                if (i_ram_ack) begin
                    ram_req_d   = 1'b0;
                    ram_we_d    = 1'b0;
                    ram_addr_d  = 16'h0000;
                    ram_wdata_d = 16'h0000;
                    ce_fetch_d  = 1'b1;
                    state_d     = S_WB;
                    if (op_q == `PRCO_OP_LW) begin
                        reg_we_d    = 1'b1;
                        reg_sel_d   = rd_q;
                        reg_wdata_d = i_ram_rdata;
                    end else begin
                        reg_we_d = 1'b0;
                    end
                end else if ((RAM_TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    ram_req_d   = 1'b0;
                    ram_we_d    = 1'b0;
                    ram_addr_d  = 16'h0000;
                    ram_wdata_d = 16'h0000;
                    bus_err_d   = 1'b1;
                    ce_fetch_d  = 1'b1;
                    state_d     = S_IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_WB: begin
                if (i_ce_ram || i_ce_reg) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            op_q        <= 5'd0;
            rd_q        <= 3'd0;
            cnt_q       <= '0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= 16'h0000;
            ram_wdata_q <= 16'h0000;
            reg_we_q    <= 1'b0;
            reg_sel_q   <= 3'd0;
            reg_wdata_q <= 16'h0000;
            pc_load_q   <= 1'b0;
            pc_target_q <= 16'h0000;
            ce_fetch_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_sel_q   <= reg_sel_d;
            reg_wdata_q <= reg_wdata_d;
            pc_load_q   <= pc_load_d;
            pc_target_q <= pc_target_d;
            ce_fetch_q  <= ce_fetch_d;
            bus_err_q   <= bus_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign q_ram_req   = ram_req_q;
    assign q_ram_we    = ram_we_q;
    assign q_ram_addr  = ram_addr_q;
    assign q_ram_wdata = ram_wdata_q;
    assign q_reg_we    = reg_we_q;
    assign q_reg_sel   = reg_sel_q;
    assign q_reg_wdata = reg_wdata_q;
    assign q_pc_load   = pc_load_q;
    assign q_pc_target = pc_target_q;
    assign q_ce_fetch  = ce_fetch_q;
    assign q_bus_err   = bus_err_q;
    assign q_overrun   = overrun_q;

endmodule

// File: doc/prco_mem_wb.md
Name: prco_mem_wb

Overview:
Memory/writeback stage of the PRCO core. It sits on the consumer side of the ALU's enable handshake and accepts one ALU result per instruction via i_ce_ram / i_ce_reg / i_should_branch. It completes LW/SW through a req/ack RAM port, writes the register file, and loads the PC for taken branches. Its single-cycle q_ce_fetch pulse re-enables fetch, which closes the in-order pipeline loop.

Parameters:
RAM_TIMEOUT, 16, cycles to wait for i_ram_ack before aborting the access; 0 disables the timeout.

Ports:
i_clk  in  1  core clock, rising edge
i_reset  in  1  synchronous reset, active-high
i_ce_ram  in  1  ALU result is a RAM access (LW/SW)
i_ce_reg  in  1  ALU result is a register/branch result
i_should_branch  in  1  taken branch, qualified by i_ce_reg
i_op  in  5  opcode, `PRCO_OP_* encoding
i_result  in  16  ALU result: address for LW/SW, value otherwise
i_store_data  in  16  data for SW
i_rd_sel  in  3  destination register index
i_branch_target  in  16  branch target address
q_ram_req  out  1  RAM request, held until ack or timeout
q_ram_we  out  1  1 = write (SW), 0 = read (LW)
q_ram_addr  out  16  RAM address
q_ram_wdata  out  16  RAM write data
i_ram_ack  in  1  RAM completion
i_ram_rdata  in  16  RAM read data, valid with ack
q_reg_we  out  1  register-file write strobe
q_reg_sel  out  3  register index
q_reg_wdata  out  16  register write data
q_pc_load  out  1  load PC strobe
q_pc_target  out  16  new PC value
q_ce_fetch  out  1  instruction retired; restart fetch
q_bus_err  out  1  one-cycle pulse on RAM timeout
q_overrun  out  1  sticky flag: input arrived while busy

Behaviour:
- Reset: all outputs are 0 and the state is IDLE. Reset wins over every other event. Reset during RAM_WAIT drops q_ram_req at that edge. An ack arriving later, in IDLE, is ignored.
- The block has three states: IDLE, RAM_WAIT and WB. Every output except q_overrun and the held RAM bus is a one-cycle pulse.
- IDLE, with i_ce_ram at cycle N:
  - Latch op, i_result, i_store_data and i_rd_sel; clear the timeout counter.
  - At N+1: q_ram_req=1, q_ram_addr=i_result, q_ram_we=(op==`PRCO_OP_SW), q_ram_wdata=i_store_data. Go to RAM_WAIT.
  - i_ce_ram takes priority when i_ce_ram and i_ce_reg are both high. q_overrun is not set in that case.
- IDLE, with i_ce_reg at cycle N:
  - Latch the inputs and go to WB. At N+1 q_ce_fetch=1.
  - q_reg_we=1 only for MOV, MOVI, ADD, ADDI, SUBI and READ, with q_reg_sel=i_rd_sel and q_reg_wdata=i_result.
  - CMP, JMP, NOP, WRITE and unknown ops do not write a register.
  - If i_should_branch=1, also q_pc_load=1 and q_pc_target=i_branch_target, with no register write.
- i_should_branch without i_ce_reg is ignored.
- RAM_WAIT:
  - q_ram_req, addr, we and wdata are held stable. i_ram_ack is sampled every cycle q_ram_req=1, including the first.
  - Ack at cycle M: drop q_ram_req at M+1. For LW at M+1: q_reg_we=1, q_reg_wdata=i_ram_rdata captured at M, q_ce_fetch=1. For SW at M+1: q_ce_fetch=1 only.
  - Timeout: the counter increments each RAM_WAIT cycle. When q_ram_req has been high RAM_TIMEOUT cycles with no ack, the next cycle drops the request and pulses q_bus_err=1 and q_ce_fetch=1. There is no register write. Return to IDLE.
  - An ack in the same cycle as timeout expiry counts as success.
- WB lasts exactly one cycle, then returns to IDLE. The earliest next accept is the cycle after WB.
- i_ce_ram or i_ce_reg arriving in RAM_WAIT or WB is dropped and sets q_overrun=1. Only reset clears q_overrun.
- i_ram_ack in IDLE or WB has no effect.
- All datapaths are 16-bit with no arithmetic. The timeout counter is wide enough for RAM_TIMEOUT and saturates rather than wrapping.

Test Plan:
1. Reset: hold i_reset 2 cycles with random inputs -> all outputs 0; q_overrun stays 0.
2. ADD: i_ce_reg, op ADD, i_result=0x1234, i_rd_sel=3 at N -> at N+1 q_reg_we=1, sel=3, wdata=0x1234, q_ce_fetch=1; all pulses 0 at N+2.
3. LW: i_ce_ram, op LW, i_result=0x0040, rd=5; ack with rdata 0xBEEF on the 3rd req cycle -> req high 3 cycles, addr=0x0040, we=0; next cycle q_reg_we=1, sel=5, wdata=0xBEEF, q_ce_fetch=1.
4. SW timeout: op SW, addr 0x0100, data 0x00AA, no ack, RAM_TIMEOUT=16 -> req=1 and we=1 for 16 cycles; then req=0, q_bus_err=1, q_ce_fetch=1, q_reg_we=0. Repeat with ack on cycle 16 -> no q_bus_err.
5. Branch: i_ce_reg + i_should_branch, op JMP, target 0x0020 -> at N+1 q_pc_load=1, q_pc_target=0x0020, q_ce_fetch=1, q_reg_we=0. CMP with i_should_branch=0 -> q_ce_fetch only.
6. Hazards: i_ce_reg during RAM_WAIT -> q_overrun=1 sticky and the LW still completes normally. Reset mid-RAM_WAIT then a late ack -> no reg write, no fetch pulse.
